// File: rtl/seg_frame_decoder.sv
// Seven-segment frame decoder: collects six active-low hex glyphs into a
// 24-bit value, flagging illegal glyphs and aborting on an idle timeout.
module seg_frame_decoder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [23:0] value,
    output logic        err,
    output logic [2:0]  err_digit,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

    localparam logic [8:0] IDLE_LIMIT = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  idle_q, idle_d;
    logic [23:0] value_q, value_d;
    logic        err_q, err_d;
    logic [2:0]  err_digit_q, err_digit_d;
    logic        timeout_q, timeout_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [4:0]  dec;

    // Returns {legal, nibble}; illegal patterns decode to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h10:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        value_d     = value_q;
        err_d       = err_q;
        err_digit_d = err_digit_q;
        timeout_d   = timeout_q;
        dec         = decode(seg_in);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = COLLECT;
                    idx_d       = 3'd0;
                    idle_d      = 8'd0;
                    value_d     = 24'd0;
                    err_d       = 1'b0;
                    err_digit_d = 3'd0;
                    timeout_d   = 1'b0;
                end
            end
            COLLECT: begin
                // Acceptance takes priority over an expiring idle counter.
                if (seg_valid) begin
                    for (int k = 0; k < 6; k++)
                        if (idx_q == 3'(k)) value_d[4*k +: 4] = dec[3:0];
                    if (!dec[4] && !err_q) begin
                        err_d       = 1'b1;
                        err_digit_d = idx_q;
                    end
                    idle_d = 8'd0;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd5) state_d = FINISH;
                end else if ({1'b0, idle_q} + 9'd1 == IDLE_LIMIT) begin
                    timeout_d = 1'b1;
                    idle_d    = 8'd0;
                    state_d   = FINISH;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == COLLECT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            idle_q      <= 8'd0;
            value_q     <= 24'd0;
            err_q       <= 1'b0;
            err_digit_q <= 3'd0;
            timeout_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            value_q     <= value_d;
            err_q       <= err_d;
            err_digit_q <= err_digit_d;
            timeout_q   <= timeout_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign err       = err_q;
    assign err_digit = err_digit_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/seg_frame_decoder.md
SEG_FRAME_DECODER -- requirements
Module: seg_frame_decoder

Interface
REQ-001 Parameter: TIMEOUT, 255, idle cycles allowed between accepted digits before a frame aborts; range 1..255.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle request to begin a new frame.
REQ-005 Port: seg_in  input  7  active-low segment pattern, bit0 = segment a through bit6 = segment g.
REQ-006 Port: seg_valid  input  1  seg_in holds a digit pattern this cycle.
REQ-007 Port: ready  output  1  block accepts a pattern this cycle.
REQ-008 Port: busy  output  1  frame in progress.
REQ-009 Port: done  output  1  one-cycle pulse; frame complete; value, err and timeout are final.
REQ-010 Port: value  output  24  decoded frame; digit i in value[4i+3:4i].
REQ-011 Port: err  output  1  at least one pattern in the frame was not a legal hex glyph.
REQ-012 Port: err_digit  output  3  index of the first illegal digit; 0 when err=0.
REQ-013 Port: timeout  output  1  frame aborted by TIMEOUT expiry.

Function
REQ-014 Legal glyphs, seg_in hex -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-015 Every other seg_in pattern is illegal; it decodes to nibble 0 and sets err.
REQ-016 FSM states: IDLE, COLLECT, FINISH.
REQ-017 IDLE -> COLLECT on start=1; on that edge: digit index=0, idle counter=0, value=0, err=0, err_digit=0, timeout=0.
REQ-018 ready=1 only in COLLECT; busy=1 in COLLECT and FINISH; a digit is accepted on a cycle with ready=1 and seg_valid=1.
REQ-019 On acceptance: decoded nibble written to value[4i+3:4i] (i = digit index); index increments; idle counter clears.
REQ-020 Digits arrive in order 0 to 5; acceptance of digit 5 moves COLLECT -> FINISH.
REQ-021 Each COLLECT cycle without acceptance increments the idle counter; reaching TIMEOUT sets timeout=1 and moves to FINISH; received digits are kept, the rest stay 0.
REQ-022 FINISH lasts exactly one cycle, with done=1, then returns to IDLE; done is 0 in every other cycle.
REQ-023 Latency: done asserts on the cycle after the edge that accepts digit 5.
REQ-024 err is sticky within a frame; err_digit latches only on the first illegal digit.
REQ-025 value, err, err_digit and timeout hold from done until the next accepted start.
REQ-026 start in COLLECT or FINISH is ignored; seg_valid outside COLLECT is ignored.
REQ-027 When acceptance and idle-counter expiry fall in the same cycle, acceptance wins and the counter clears.
REQ-028 All outputs are registered.

Reset
REQ-029 reset=1 forces IDLE immediately, independent of clock: ready=0, busy=0, done=0, value=0, err=0, err_digit=0, timeout=0; index and idle counter=0.
REQ-030 Reset during COLLECT discards the partial frame; no done pulse follows.
REQ-031 After reset deasserts, the first start is honoured on the next rising edge.

Verification
REQ-032 start, then patterns 79,24,30,19,12,02 on consecutive cycles -> done one cycle after the last, value=654321, err=0, timeout=0.
REQ-033 Frame of 40,7F,00,08,03,46 -> value=CBA800, err=1, err_digit=1.
REQ-034 Frame with gaps of 3 idle cycles between digits, TIMEOUT=4 -> completes normally; gap of 4 cycles after digit 2 -> timeout=1, done pulses, value holds digits 0..2 only.
REQ-035 start pulsed again mid-frame -> ignored; frame and value unchanged.
REQ-036 reset asserted mid-cycle after digit 3 -> all outputs 0 immediately, no done; a following full frame decodes correctly.
REQ-037 Sweep all 128 seg_in values into digit 0 -> exactly the 16 glyphs of REQ-014 leave err=0, with the correct nibble.
